mem_subsys: RTL
===============

# mem_subsys

Parametrised successor to the fixed 1K×32 dual-port instruction/data memory used under the RISC-V CPU. It serves a single-cycle instruction port and a data port with a valid/ready handshake, byte-lane write enables and a configurable number of wait states. A small MMIO window provides a `tohost`/halt register and a free-running cycle counter. It sits between `riscv` and the top-level system wrapper.

## Interface
- `DATA_W`, 32: data width; must be a multiple of 8.
- `ADDR_W`, 30: word-address width.
- `DEPTH`, 1024: RAM depth in words.
- `WAIT_STATES`, 0: extra data-port latency in cycles, 0..15.
- `MMIO_BASE`, 30'h3FFF_FF00: word address of the MMIO window; the window is 2 words.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-low reset.
- `pc` in ADDR_W: instruction word address.
- `instr` out DATA_W: instruction read data.
- `dmem_req` in 1: data request valid.
- `dmem_we` in 1: 1 = write, 0 = read.
- `dmem_be` in DATA_W/8: byte-lane enables for writes.
- `dmem_addr` in ADDR_W: data word address.
- `dmem_wdata` in DATA_W: write data.
- `dmem_ready` out 1: request is accepted this cycle.
- `dmem_rvalid` out 1: response pulse; read data is valid and the write has completed.
- `dmem_rdata` out DATA_W: read data; 0 for writes.
- `tohost` out DATA_W: last value written to MMIO word 0.
- `halt` out 1: sticky; set by a `tohost` write with `wdata[0]=1`.
- `addr_err` out 1: sticky; set by any out-of-range access.

## Operation
- **Instruction port:** always reads. `instr` at cycle N+1 holds RAM[`pc` at cycle N].
  - An out-of-range `pc` (≥DEPTH and not MMIO) returns 0 and sets `addr_err`.
  - The instruction port never reads MMIO; an MMIO `pc` returns 0 and sets `addr_err`.
- **Data FSM states:** IDLE, WAIT, RESP.
  - IDLE: `dmem_ready=1`. On `dmem_req` the request (we, be, addr, wdata) is latched. The FSM goes to WAIT if WAIT_STATES>0, otherwise to RESP.
  - WAIT: `dmem_ready=0`. The counter loads WAIT_STATES−1 and decrements. At 0 the FSM goes to RESP.
  - RESP: `dmem_rvalid=1`, `dmem_ready=1`. A new `dmem_req` is accepted here (back-to-back). The next state is then WAIT or RESP. Without a request it returns to IDLE.
- **Commit point:** the latched access executes on the edge entering RESP. RAM writes update only the enabled byte lanes. Read data is captured on that same edge.
- **Same-address collision:** if the instruction port reads the word being written on the same edge, `instr` returns the old data.
- **MMIO window:**
  - Word MMIO_BASE+0 (`tohost`) is read/write and obeys byte enables. A write with `wdata[0]=1` and `be[0]=1` sets `halt`.
  - Word MMIO_BASE+1 is the cycle counter. It increments every cycle while `halt=0` and wraps at 2^DATA_W. It is read-only; writes are ignored and do not set `addr_err`.
- **Out-of-range data access** (≥DEPTH and not MMIO): reads return 0, writes are dropped, and `addr_err` is set. The handshake completes normally.
- **After `halt`:** the data port keeps operating; only the counter freezes.

## Timing
- **Reset values:** `instr`=0, `dmem_ready`=0 during reset and 1 on the first cycle after. All other outputs (`dmem_rvalid`, `dmem_rdata`, `tohost`, `halt`, `addr_err`) and the counter reset to 0. The FSM goes to IDLE. RAM contents are not reset.
- **Data latency:** a request accepted at cycle N gives `dmem_rvalid` at N+1+WAIT_STATES.
- **Throughput:** 1 request/cycle when WAIT_STATES=0, otherwise 1 per WAIT_STATES+1 cycles.
- **Reset mid-transaction:** the pending access is discarded and no write occurs. A write whose commit edge coincides with reset deassertion is also discarded, because reset has priority.
- `dmem_rdata` holds its value outside `rvalid`.

## Structure
- Package `mem_subsys_pkg` holds:
  - the `state_t` enum (IDLE, WAIT, RESP);
  - MMIO offsets `MMIO_TOHOST=0` and `MMIO_CYCLE=1`;
  - the default `MMIO_BASE`.
- Sub-module `bram_dp_be`: a two-port, byte-enabled RAM (port A read-only, port B read/write) with registered outputs and read-old-on-collision.
- Top level: FSM, wait counter, address decode, MMIO registers and sticky flags.

## Test plan
- **Back-to-back, WAIT_STATES=0:** write 0xDEADBEEF to word 5, then read word 5 on the next cycle → `rvalid` on both response cycles, `rdata`=0xDEADBEEF, `dmem_ready` never drops.
- **Byte lanes:** word 7 = 0x11223344; write `be`=4'b0101 with `wdata`=0xAABBCCDD → reading word 7 returns 0x11BB33DD.
- **WAIT_STATES=3:** read accepted at cycle 10 → `dmem_ready`=0 on cycles 11–13, `rvalid` at cycle 14.
- **MMIO:** write 0x1 to MMIO_BASE → `tohost`=1, `halt`=1, and the counter read at MMIO_BASE+1 is identical on two reads 5 cycles apart.
- **Out of range:** read DEPTH+3 → `rdata`=0 and `addr_err`=1, still set after 10 idle cycles. `pc`=DEPTH → `instr`=0.
- **Reset mid-WAIT:** with WAIT_STATES=4, assert `rst`=0 two cycles after accepting a write to word 9 → word 9 unchanged, `rvalid` never pulses, `dmem_ready`=1 one cycle after release.

Source files
------------

// File: rtl/mem_subsys_pkg.sv
// Shared types and constants for the instruction/data memory subsystem.
package mem_subsys_pkg;

  // Data-port handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Where the data-port read value comes from after a commit.
  typedef enum logic {
    RD_REG = 1'b0,
    RD_RAM = 1'b1
  } rd_src_t;

  // Word offsets inside the two-word MMIO window.
  localparam int MMIO_TOHOST = 0;
  localparam int MMIO_CYCLE  = 1;

  localparam logic [29:0] MMIO_BASE_DEFAULT = 30'h3FFF_FF00;

endpackage

// File: rtl/bram_dp_be.sv
// Two-port RAM: port A read-only, port B read/write with byte enables.
// Both outputs are registered; a same-edge read of a word being written
// returns the old contents.
module bram_dp_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                  clk,
  input  logic [AW-1:0]         a_addr,
  output logic [DATA_W-1:0]     a_dout,
  input  logic                  b_en,
  input  logic [DATA_W/8-1:0]   b_we,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_W-1:0]     b_din,
  output logic [DATA_W-1:0]     b_dout
);

  localparam int NB = DATA_W / 8;

  // NOTE: the array is deliberately not reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  // Port A: unconditional registered read.
  always_ff @(posedge clk) begin
    a_dout <= mem[a_addr];
  end

  // Port B: byte-lane writes and a registered read of the pre-write word.
  always_ff @(posedge clk) begin
    if (b_en) begin
      for (int i = 0; i < NB; i++) begin
        if (b_we[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
      end
      b_dout <= mem[b_addr];
    end
  end

endmodule

// File: rtl/mem_subsys.sv
// Instruction/data memory with a wait-state data handshake and a small
// MMIO window (tohost/halt register and a free-running cycle counter).
module mem_subsys
  import mem_subsys_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 30,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = ADDR_W'(MMIO_BASE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     pc,
  output logic [DATA_W-1:0]     instr,
  input  logic                  dmem_req,
  input  logic                  dmem_we,
  input  logic [DATA_W/8-1:0]   dmem_be,
  input  logic [ADDR_W-1:0]     dmem_addr,
  input  logic [DATA_W-1:0]     dmem_wdata,
  output logic                  dmem_ready,
  output logic                  dmem_rvalid,
  output logic [DATA_W-1:0]     dmem_rdata,
  output logic [DATA_W-1:0]     tohost,
  output logic                  halt,
  output logic                  addr_err
);

  localparam int                NB          = DATA_W / 8;
  localparam int                IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_LIM   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] TOHOST_ADDR = MMIO_BASE + ADDR_W'(MMIO_TOHOST);
  localparam logic [ADDR_W-1:0] CYCLE_ADDR  = MMIO_BASE + ADDR_W'(MMIO_CYCLE);
  localparam logic [3:0]        WS_LOAD     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef struct packed {
    logic              we;
    logic [NB-1:0]     be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  dreq_t             req_q, exec;
  logic              accept, commit;
  logic              pc_in_ram, pc_ok_q;
  logic              d_in_ram, d_is_tohost, d_is_cycle;
  logic [DATA_W-1:0] a_dout, b_dout, cycle_q, rd_reg_q;
  rd_src_t           rd_sel_q;

  // Handshake outputs and next state; ready is held low while in reset.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d     = state_q;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_ready = rst;
        if (dmem_req && rst) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP: begin
        dmem_ready  = rst;
        dmem_rvalid = 1'b1;
        if (dmem_req && rst) state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = dmem_req && dmem_ready;
  // The access executes on the edge that enters RESP; reset wins over it.
  assign commit = rst && (state_d == RESP);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_d == WAIT && state_q != WAIT) cnt_q <= WS_LOAD;
      else if (state_q == WAIT)               cnt_q <= cnt_q - 4'd1;
    end
  end

  // Request capture; pure datapath, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) req_q <= '{we: dmem_we, be: dmem_be, addr: dmem_addr, wdata: dmem_wdata};
  end

  // With no wait states the request commits on its own acceptance edge.
  always_comb begin
    if (WAIT_STATES == 0) exec = '{we: dmem_we, be: dmem_be, addr: dmem_addr, wdata: dmem_wdata};
    else                  exec = req_q;
  end

  assign pc_in_ram   = ({1'b0, pc} < DEPTH_LIM);
  assign d_in_ram    = ({1'b0, exec.addr} < DEPTH_LIM);
  assign d_is_tohost = (exec.addr == TOHOST_ADDR);
  assign d_is_cycle  = (exec.addr == CYCLE_ADDR);

  bram_dp_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_ram (
    .clk    (clk),
    .a_addr (pc[IDX_W-1:0]),
    .a_dout (a_dout),
    .b_en   (commit && d_in_ram),
    .b_we   (exec.we ? exec.be : '0),
    .b_addr (exec.addr[IDX_W-1:0]),
    .b_din  (exec.wdata),
    .b_dout (b_dout)
  );

  // MMIO registers, sticky flags and read-data source selection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_ok_q  <= 1'b0;
      cycle_q  <= '0;
      tohost   <= '0;
      halt     <= 1'b0;
      addr_err <= 1'b0;
      rd_sel_q <= RD_REG;
      rd_reg_q <= '0;
    end else begin
      pc_ok_q <= pc_in_ram;
      if (!halt)      cycle_q  <= cycle_q + DATA_W'(1);
      if (!pc_in_ram) addr_err <= 1'b1;
      if (commit) begin
        rd_sel_q <= (!exec.we && d_in_ram) ? RD_RAM : RD_REG;
        rd_reg_q <= '0;
        if (d_is_tohost) begin
          if (exec.we) begin
            for (int i = 0; i < NB; i++) begin
              if (exec.be[i]) tohost[8*i +: 8] <= exec.wdata[8*i +: 8];
            end
            if (exec.be[0] && exec.wdata[0]) halt <= 1'b1;
          end else begin
            rd_reg_q <= tohost;
          end
        end else if (d_is_cycle) begin
          if (!exec.we) rd_reg_q <= cycle_q;
        end else if (!d_in_ram) begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  assign instr      = pc_ok_q ? a_dout : '0;
  assign dmem_rdata = (rd_sel_q == RD_RAM) ? b_dout : rd_reg_q;

endmodule
